// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Groups the pipeline-side signals of the hazard controller.
//   master : the pipeline. It drives the redirect, destination, source,
//            multi-cycle and counter-clear inputs, and reads the controls.
//   slave  : hazard_ctrl. It reads the pipeline state and drives the
//            stage write enables and clears, the forwarding selects, the
//            multi-cycle status and the performance counters.
// REG_AW and CNT_W must match the parameters of the attached hazard_ctrl.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  // Redirect resolved in EX/MEM
  logic              pcsel_exmem;
  logic              is_br_exmem;
  logic              is_uncbr_exmem;
  // Destination writes in flight
  logic              rdwren_idex;
  logic              rdwren_exmem;
  logic              rdwren_memwb;
  logic              memrden_idex;
  logic [REG_AW-1:0] rd_idex;
  logic [REG_AW-1:0] rd_exmem;
  logic [REG_AW-1:0] rd_memwb;
  // Sources read in ID and EX
  logic [REG_AW-1:0] rs1_ifid;
  logic [REG_AW-1:0] rs2_ifid;
  logic              rs1used_ifid;
  logic              rs2used_ifid;
  logic [REG_AW-1:0] rs1_idex;
  logic [REG_AW-1:0] rs2_idex;
  logic              md_start_idex;
  logic              cnt_clr;
  // Pipeline controls
  logic              pc_wren;
  logic              wren_ifid;
  logic              wren_idex;
  logic              clear_ifid;
  logic              clear_idex;
  logic              clear_exmem;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              md_busy;
  logic              md_done;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output pcsel_exmem, is_br_exmem, is_uncbr_exmem,
    output rdwren_idex, rdwren_exmem, rdwren_memwb, memrden_idex,
    output rd_idex, rd_exmem, rd_memwb,
    output rs1_ifid, rs2_ifid, rs1used_ifid, rs2used_ifid,
    output rs1_idex, rs2_idex, md_start_idex, cnt_clr,
    input  pc_wren, wren_ifid, wren_idex,
    input  clear_ifid, clear_idex, clear_exmem,
    input  fwd_a_sel, fwd_b_sel, md_busy, md_done,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  pcsel_exmem, is_br_exmem, is_uncbr_exmem,
    input  rdwren_idex, rdwren_exmem, rdwren_memwb, memrden_idex,
    input  rd_idex, rd_exmem, rd_memwb,
    input  rs1_ifid, rs2_ifid, rs1used_ifid, rs2used_ifid,
    input  rs1_idex, rs2_idex, md_start_idex, cnt_clr,
    output pc_wren, wren_ifid, wren_idex,
    output clear_ifid, clear_idex, clear_exmem,
    output fwd_a_sel, fwd_b_sel, md_busy, md_done,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard unit for a 5-stage in-order core.
//   - Flushes IF/ID, ID/EX and EX/MEM on a taken branch or jump in EX/MEM.
//   - Holds the front of the pipe while a multi-cycle (mul/div) op occupies
//     EX for MD_CYCLES cycles.
//   - Stalls ID on read-after-write hazards: on every one (FWD_EN=0) or only
//     on load-use (FWD_EN=1, with EX/MEM and MEM/WB forwarding selects).
//   - Counts stall and flush cycles in saturating counters.
// Priority: flush > multi-cycle stall > data stall > normal.
// Ports:
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset; also forces safe outputs
//   bus     : hazard_ctrl_if.slave, pipeline state in, controls out
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int FWD_EN    = 0,
  parameter int REG_AW    = 5,
  parameter int MD_CYCLES = 4,
  parameter int CNT_W     = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  hazard_ctrl_if.slave  bus
);

  localparam int              MDCW    = $clog2(MD_CYCLES);
  localparam logic [MDCW-1:0] MD_LOAD = MDCW'(MD_CYCLES - 2);

  typedef enum logic {IDLE, BUSY} md_state_e;

  md_state_e        md_state, md_state_d;
  logic [MDCW-1:0]  md_cnt, md_cnt_d;
  logic             md_stall, md_done_int;
  logic             flush, data_hazard;
  logic [1:0]       fwd_a_raw, fwd_b_raw;
  logic             pc_wren;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // A source depends on an in-flight write only if it is really read, is not
  // x0 (hard-wired zero) and the producer actually writes back.
  function automatic logic src_hit(input logic [REG_AW-1:0] rs, input logic used,
                                   input logic [REG_AW-1:0] rd, input logic we);
    return used && we && (rs != '0) && (rs == rd);
  endfunction

  // EX/MEM holds the younger result, so it wins over MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (bus.rdwren_exmem && (rs != '0) && (rs == bus.rd_exmem))      return 2'b01;
    else if (bus.rdwren_memwb && (rs != '0) && (rs == bus.rd_memwb)) return 2'b10;
    else                                                             return 2'b00;
  endfunction

  assign flush = bus.pcsel_exmem && (bus.is_br_exmem || bus.is_uncbr_exmem);

  generate
    if (FWD_EN != 0) begin : g_fwd
      // Only a load in EX cannot be forwarded in time.
      assign data_hazard = bus.memrden_idex &&
        (src_hit(bus.rs1_ifid, bus.rs1used_ifid, bus.rd_idex, bus.rdwren_idex) ||
         src_hit(bus.rs2_ifid, bus.rs2used_ifid, bus.rd_idex, bus.rdwren_idex));
      assign fwd_a_raw = fwd_sel(bus.rs1_idex);
      assign fwd_b_raw = fwd_sel(bus.rs2_idex);
    end else begin : g_nofwd
      // Regfile is write-first, so a producer in MEM/WB is already visible.
      assign data_hazard =
        src_hit(bus.rs1_ifid, bus.rs1used_ifid, bus.rd_idex,  bus.rdwren_idex)  ||
        src_hit(bus.rs1_ifid, bus.rs1used_ifid, bus.rd_exmem, bus.rdwren_exmem) ||
        src_hit(bus.rs2_ifid, bus.rs2used_ifid, bus.rd_idex,  bus.rdwren_idex)  ||
        src_hit(bus.rs2_ifid, bus.rs2used_ifid, bus.rd_exmem, bus.rdwren_exmem);
      assign fwd_a_raw = 2'b00;
      assign fwd_b_raw = 2'b00;
    end
  endgenerate

  // Multi-cycle FSM. The IDLE cycle that sees md_start_idex is the first of
  // the MD_CYCLES EX cycles, so BUSY counts down from MD_CYCLES-2 and the
  // release (md_done) cycle is the one where the counter reads zero.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    md_state_d  = md_state;
    md_cnt_d    = md_cnt;
    md_stall    = 1'b0;
    md_done_int = 1'b0;
    case (md_state)
      IDLE: begin
        md_stall = bus.md_start_idex;
        if (bus.md_start_idex) begin
          md_state_d = BUSY;
          md_cnt_d   = MD_LOAD;
        end
      end
      BUSY: begin
        if (md_cnt != '0) begin
          md_stall = 1'b1;
          md_cnt_d = md_cnt - 1'b1;
        end else begin
          md_done_int = 1'b1;
          md_state_d  = IDLE;
        end
      end
    endcase
    // A redirect kills whatever op sits in EX.
    if (flush) begin
      md_state_d  = IDLE;
      md_cnt_d    = '0;
      md_done_int = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      md_state <= IDLE;
      md_cnt   <= '0;
    end else begin
      md_state <= md_state_d;
      md_cnt   <= md_cnt_d;
    end
  end

  // Pipeline controls. Reset is decoded combinationally so the pipe is frozen
  // and cleared the moment i_rst_n falls, not at the next edge.
  always_comb begin
    pc_wren         = 1'b1;
    bus.wren_ifid   = 1'b1;
    bus.wren_idex   = 1'b1;
    bus.clear_ifid  = 1'b0;
    bus.clear_idex  = 1'b0;
    bus.clear_exmem = 1'b0;
    if (!i_rst_n) begin
      pc_wren         = 1'b0;
      bus.wren_ifid   = 1'b0;
      bus.wren_idex   = 1'b0;
      bus.clear_ifid  = 1'b1;
      bus.clear_idex  = 1'b1;
      bus.clear_exmem = 1'b1;
    end else if (flush) begin
      bus.clear_ifid  = 1'b1;
      bus.clear_idex  = 1'b1;
      bus.clear_exmem = 1'b1;
    end else if (md_stall) begin
      // Whole front end holds; EX/MEM takes bubbles until the op completes.
      // A coincident data hazard is absorbed here with no ID/EX bubble.
      pc_wren         = 1'b0;
      bus.wren_ifid   = 1'b0;
      bus.wren_idex   = 1'b0;
      bus.clear_exmem = 1'b1;
    end else if (data_hazard) begin
      // Hold IF and ID; ID/EX is written with a bubble.
      pc_wren         = 1'b0;
      bus.wren_ifid   = 1'b0;
      bus.clear_idex  = 1'b1;
    end
  end

  assign bus.pc_wren   = pc_wren;
  assign bus.fwd_a_sel = i_rst_n ? fwd_a_raw : 2'b00;
  assign bus.fwd_b_sel = i_rst_n ? fwd_b_raw : 2'b00;
  assign bus.md_busy   = i_rst_n && (md_state == BUSY);
  assign bus.md_done   = i_rst_n && md_done_int;

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (bus.cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_wren && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != '1))    flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Two hazard_ctrl instances share one stimulus stream:
//   u0 : FWD_EN=0, MD_CYCLES=4, CNT_W=4 (counters saturate quickly)
//   u1 : FWD_EN=1, MD_CYCLES=3, CNT_W=5
// A behavioural model tracks each multi-cycle op as "cycles elapsed since it
// entered EX" and derives the expected controls from the hazard rules.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int AW = 5;

  typedef struct {
    bit          pcsel, is_br, is_uncbr;
    bit          we_idex, we_exmem, we_memwb, memrd;
    bit [AW-1:0] rd_idex, rd_exmem, rd_memwb;
    bit [AW-1:0] rs1_ifid, rs2_ifid;
    bit          u1, u2;
    bit [AW-1:0] rs1_idex, rs2_idex;
    bit          md_start, cnt_clr;
  } stim_t;

  localparam int FE  [2] = '{0, 1};
  localparam int MDC [2] = '{4, 3};
  localparam int MAXC[2] = '{15, 31};

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  stim_t cur = '{default: 0};
  int    checks = 0;
  int    errors = 0;

  // Model state: md_k < 0 means no op in EX, otherwise EX cycles already spent.
  int md_k[2];
  int scnt[2];
  int fcnt[2];

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(AW), .CNT_W(4)) if0 ();
  hazard_ctrl_if #(.REG_AW(AW), .CNT_W(5)) if1 ();

  hazard_ctrl #(.FWD_EN(0), .REG_AW(AW), .MD_CYCLES(4), .CNT_W(4)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if0.slave));
  hazard_ctrl #(.FWD_EN(1), .REG_AW(AW), .MD_CYCLES(3), .CNT_W(5)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if1.slave));

  assign if0.pcsel_exmem = cur.pcsel;    assign if1.pcsel_exmem = cur.pcsel;
  assign if0.is_br_exmem = cur.is_br;    assign if1.is_br_exmem = cur.is_br;
  assign if0.is_uncbr_exmem = cur.is_uncbr; assign if1.is_uncbr_exmem = cur.is_uncbr;
  assign if0.rdwren_idex = cur.we_idex;  assign if1.rdwren_idex = cur.we_idex;
  assign if0.rdwren_exmem = cur.we_exmem; assign if1.rdwren_exmem = cur.we_exmem;
  assign if0.rdwren_memwb = cur.we_memwb; assign if1.rdwren_memwb = cur.we_memwb;
  assign if0.memrden_idex = cur.memrd;   assign if1.memrden_idex = cur.memrd;
  assign if0.rd_idex = cur.rd_idex;      assign if1.rd_idex = cur.rd_idex;
  assign if0.rd_exmem = cur.rd_exmem;    assign if1.rd_exmem = cur.rd_exmem;
  assign if0.rd_memwb = cur.rd_memwb;    assign if1.rd_memwb = cur.rd_memwb;
  assign if0.rs1_ifid = cur.rs1_ifid;    assign if1.rs1_ifid = cur.rs1_ifid;
  assign if0.rs2_ifid = cur.rs2_ifid;    assign if1.rs2_ifid = cur.rs2_ifid;
  assign if0.rs1used_ifid = cur.u1;      assign if1.rs1used_ifid = cur.u1;
  assign if0.rs2used_ifid = cur.u2;      assign if1.rs2used_ifid = cur.u2;
  assign if0.rs1_idex = cur.rs1_idex;    assign if1.rs1_idex = cur.rs1_idex;
  assign if0.rs2_idex = cur.rs2_idex;    assign if1.rs2_idex = cur.rs2_idex;
  assign if0.md_start_idex = cur.md_start; assign if1.md_start_idex = cur.md_start;
  assign if0.cnt_clr = cur.cnt_clr;      assign if1.cnt_clr = cur.cnt_clr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit reads(input bit [AW-1:0] rs, input bit used,
                               input bit [AW-1:0] rd, input bit we);
    return used && we && rs != 0 && rs == rd;
  endfunction

  function automatic bit [1:0] src_of(input stim_t s, input bit [AW-1:0] rs);
    if (rs == 0) return 2'd0;
    if (s.we_exmem && s.rd_exmem == rs) return 2'd1;
    if (s.we_memwb && s.rd_memwb == rs) return 2'd2;
    return 2'd0;
  endfunction

  // Expected controls {pc_wren, wren_ifid, wren_idex, clear_ifid, clear_idex,
  // clear_exmem}, selects {b, a}, md status; advances the model one cycle.
  function automatic void model(input int i, input stim_t s, output logic [5:0] ctrl,
                                output logic [3:0] fwd, output logic busy,
                                output logic done);
    bit flush, haz, stall;
    int k;
    flush = s.pcsel && (s.is_br || s.is_uncbr);
    if (FE[i] == 0)
      haz = reads(s.rs1_ifid, s.u1, s.rd_idex, s.we_idex)  ||
            reads(s.rs1_ifid, s.u1, s.rd_exmem, s.we_exmem) ||
            reads(s.rs2_ifid, s.u2, s.rd_idex, s.we_idex)  ||
            reads(s.rs2_ifid, s.u2, s.rd_exmem, s.we_exmem);
    else
      haz = s.memrd && (reads(s.rs1_ifid, s.u1, s.rd_idex, s.we_idex) ||
                        reads(s.rs2_ifid, s.u2, s.rd_idex, s.we_idex));
    busy = md_k[i] >= 0;
    k = md_k[i];
    if (k < 0 && s.md_start) k = 0;
    stall = k >= 0 && k < MDC[i] - 1;
    done  = k == MDC[i] - 1 && !flush;
    if (flush)      ctrl = 6'b111111;
    else if (stall) ctrl = 6'b000001;
    else if (haz)   ctrl = 6'b001010;
    else            ctrl = 6'b111000;
    fwd = (FE[i] != 0) ? {src_of(s, s.rs2_idex), src_of(s, s.rs1_idex)} : 4'd0;
    md_k[i] = (!flush && stall) ? k + 1 : -1;
    if (s.cnt_clr) begin
      scnt[i] = 0;
      fcnt[i] = 0;
    end else begin
      if (!ctrl[5] && scnt[i] < MAXC[i]) scnt[i]++;
      if (flush && fcnt[i] < MAXC[i])    fcnt[i]++;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      md_k[i] = -1;
      scnt[i] = 0;
      fcnt[i] = 0;
    end
  endfunction

  // One cycle: drive at the falling edge, check before the rising edge.
  task automatic step(input stim_t s, input string tag);
    logic [5:0]  obs_c[2], exp_c;
    logic [3:0]  obs_f[2], exp_f;
    logic [1:0]  obs_m[2];
    logic [63:0] obs_s[2], obs_l[2];
    logic        b, d;
    int          es, ef;
    @(negedge clk);
    cur = s;
    #1;
    obs_c[0] = {if0.pc_wren, if0.wren_ifid, if0.wren_idex, if0.clear_ifid, if0.clear_idex, if0.clear_exmem};
    obs_c[1] = {if1.pc_wren, if1.wren_ifid, if1.wren_idex, if1.clear_ifid, if1.clear_idex, if1.clear_exmem};
    obs_f[0] = {if0.fwd_b_sel, if0.fwd_a_sel};
    obs_f[1] = {if1.fwd_b_sel, if1.fwd_a_sel};
    obs_m[0] = {if0.md_busy, if0.md_done};
    obs_m[1] = {if1.md_busy, if1.md_done};
    obs_s[0] = 64'(if0.stall_cnt);  obs_l[0] = 64'(if0.flush_cnt);
    obs_s[1] = 64'(if1.stall_cnt);  obs_l[1] = 64'(if1.flush_cnt);
    for (int i = 0; i < 2; i++) begin
      es = scnt[i];
      ef = fcnt[i];
      model(i, s, exp_c, exp_f, b, d);
      check($sformatf("%s u%0d ctrl", tag, i), 64'(obs_c[i]), 64'(exp_c));
      check($sformatf("%s u%0d fwd", tag, i), 64'(obs_f[i]), 64'(exp_f));
      check($sformatf("%s u%0d md", tag, i), 64'(obs_m[i]), 64'({b, d}));
      check($sformatf("%s u%0d stall_cnt", tag, i), obs_s[i], 64'(es));
      check($sformatf("%s u%0d flush_cnt", tag, i), obs_l[i], 64'(ef));
    end
  endtask

  initial begin
    stim_t s;
    model_reset();

    // Outputs forced while reset is held.
    #12;
    check("rst ctrl u0", 64'({if0.pc_wren, if0.wren_ifid, if0.wren_idex, if0.clear_ifid, if0.clear_idex, if0.clear_exmem}), 64'h07);
    check("rst ctrl u1", 64'({if1.pc_wren, if1.wren_ifid, if1.wren_idex, if1.clear_ifid, if1.clear_idex, if1.clear_exmem}), 64'h07);
    check("rst md u0", 64'({if0.md_busy, if0.md_done, if0.fwd_a_sel, if0.fwd_b_sel}), 64'h0);
    check("rst cnt u0", 64'({if0.stall_cnt, if0.flush_cnt}), 64'h0);
    rst_n = 1'b1;

    // RAW on rs1 against ID/EX: u0 stalls, u1 does not (not a load).
    s = '{default: 0};
    s.rs1_ifid = 5; s.u1 = 1; s.rd_idex = 5; s.we_idex = 1;
    step(s, "raw_idex");
    // EX/MEM forwarding on rs1_idex, then the load-use case.
    s.rs1_idex = 5; s.rd_exmem = 5; s.we_exmem = 1;
    step(s, "fwd_exmem");
    check("fwd_a u1", 64'(if1.fwd_a_sel), 64'd1);
    s.memrd = 1;
    step(s, "load_use");
    check("load_use stall u1", 64'(if1.pc_wren), 64'd0);
    // MEM/WB forward on rs2 while EX/MEM covers rs1.
    s = '{default: 0};
    s.rs1_idex = 3; s.rd_exmem = 3; s.we_exmem = 1;
    s.rs2_idex = 2; s.rd_memwb = 2; s.we_memwb = 1;
    step(s, "fwd_mix");
    // x0 never matches.
    s = '{default: 0};
    s.rs2_ifid = 0; s.u2 = 1; s.rd_idex = 0; s.we_idex = 1; s.memrd = 1;
    step(s, "x0");
    check("x0 no stall u0", 64'(if0.pc_wren), 64'd1);

    // Multi-cycle op held in EX, with a coincident data hazard.
    s = '{default: 0};
    s.md_start = 1; s.rs1_ifid = 7; s.u1 = 1; s.rd_idex = 7; s.we_idex = 1;
    for (int c = 0; c < 4; c++) step(s, $sformatf("md%0d", c));
    check("md_done c3 u0", 64'(if0.md_done), 64'd1);
    s = '{default: 0};
    step(s, "md_idle");
    check("md idle u0", 64'(if0.md_busy), 64'd0);

    // Flush in the second BUSY cycle kills the op.
    s = '{default: 0};
    s.cnt_clr = 1;
    step(s, "clr0");
    s.cnt_clr = 0; s.md_start = 1;
    step(s, "mdf0");
    step(s, "mdf1");
    s.pcsel = 1; s.is_br = 1;
    step(s, "mdf_flush");
    check("flush clears u0", 64'({if0.clear_ifid, if0.clear_idex, if0.clear_exmem}), 64'h7);
    s = '{default: 0};
    step(s, "mdf_after");
    check("killed op u0", 64'({if0.md_busy, if0.md_done}), 64'h0);
    check("flush_cnt u0", 64'(if0.flush_cnt), 64'd1);

    // Stall counter saturation on the 4-bit instance, then clear.
    s = '{default: 0};
    s.rs1_ifid = 4; s.u1 = 1; s.rd_exmem = 4; s.we_exmem = 1;
    for (int c = 0; c < 20; c++) step(s, "sat");
    check("sat u0", 64'(if0.stall_cnt), 64'hF);
    s = '{default: 0};
    s.cnt_clr = 1; s.rs1_ifid = 4; s.u1 = 1; s.rd_exmem = 4; s.we_exmem = 1;
    step(s, "clr_vs_inc");
    s = '{default: 0};
    step(s, "after_clr");
    check("clr u0", 64'(if0.stall_cnt), 64'd0);

    // Asynchronous reset in the middle of a BUSY op.
    s = '{default: 0};
    s.md_start = 1;
    step(s, "pre_rst");
    @(posedge clk);
    #2;
    check("pre_rst busy u0", 64'(if0.md_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async busy u0", 64'({if0.md_busy, if1.md_busy}), 64'h0);
    check("async cnt u0", 64'({if0.stall_cnt, if0.flush_cnt}), 64'h0);
    check("async ctrl u0", 64'({if0.pc_wren, if0.wren_ifid, if0.wren_idex, if0.clear_ifid, if0.clear_idex, if0.clear_exmem}), 64'h07);
    model_reset();
    @(negedge clk);
    cur = '{default: 0};
    #2;
    rst_n = 1'b1;
    s = '{default: 0};
    step(s, "post_rst");

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      s.pcsel    = ($urandom_range(0, 7) == 0);
      s.is_br    = $urandom_range(0, 1);
      s.is_uncbr = $urandom_range(0, 1);
      s.we_idex  = $urandom_range(0, 1);
      s.we_exmem = $urandom_range(0, 1);
      s.we_memwb = $urandom_range(0, 1);
      s.memrd    = $urandom_range(0, 1);
      s.rd_idex  = AW'($urandom_range(0, 3));
      s.rd_exmem = AW'($urandom_range(0, 3));
      s.rd_memwb = AW'($urandom_range(0, 3));
      s.rs1_ifid = AW'($urandom_range(0, 3));
      s.rs2_ifid = AW'($urandom_range(0, 3));
      s.u1       = $urandom_range(0, 1);
      s.u2       = $urandom_range(0, 1);
      s.rs1_idex = AW'($urandom_range(0, 3));
      s.rs2_idex = AW'($urandom_range(0, 3));
      s.md_start = ($urandom_range(0, 3) == 0);
      s.cnt_clr  = ($urandom_range(0, 39) == 0);
      step(s, $sformatf("rnd%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter FWD_EN, default 0; 0 = stall on every RAW hazard, 1 = forward, stall only on load-use.
REQ-002 Parameter REG_AW, default 5; register-index width.
REQ-003 Parameter MD_CYCLES, default 4; EX occupancy of a multi-cycle (mul/div) op. Legal range is >=2.
REQ-004 Parameter CNT_W, default 32; performance-counter width.
REQ-005 Clock: i_clk, input, 1 bit; single clock, rising edge.
REQ-006 Reset: i_rst_n, input, 1 bit; asynchronous, active-low.
REQ-007 Redirect inputs, 1 bit each: pcsel_exmem (taken), is_br_exmem, is_uncbr_exmem.
REQ-008 Destination-write inputs, 1 bit each: rdwren_idex, rdwren_exmem, rdwren_memwb, memrden_idex (EX op is a load).
REQ-009 Destination indices, input, REG_AW each: rd_idex, rd_exmem, rd_memwb.
REQ-010 ID source inputs: rs1_ifid and rs2_ifid (REG_AW); rs1used_ifid and rs2used_ifid (1 bit).
REQ-011 EX source inputs: rs1_idex and rs2_idex (REG_AW); md_start_idex (1 bit, EX holds a multi-cycle op).
REQ-012 cnt_clr, input, 1 bit; synchronous clear of the performance counters.
REQ-013 Pipeline-control outputs, 1 bit each: pc_wren, wren_ifid, wren_idex, clear_ifid, clear_idex, clear_exmem.
REQ-014 fwd_a_sel and fwd_b_sel, output, 2 bits each; 00 = regfile, 01 = EX/MEM result, 10 = MEM/WB result.
REQ-015 md_busy, output, 1 bit; md_done, output, 1 bit (single-cycle release pulse).
REQ-016 stall_cnt and flush_cnt, output, CNT_W each.

Function
REQ-017 Every output SHALL be driven on every path each cycle; the block SHALL infer no latches.
REQ-018 Register index 0 SHALL never match; an unused source (rsXused_ifid=0) SHALL never match.
REQ-019 A flush SHALL occur when pcsel_exmem=1 and (is_br_exmem or is_uncbr_exmem) is 1.
REQ-020 Data hazard when FWD_EN=0: a used ID source equals rd_idex with rdwren_idex=1, or equals rd_exmem with rdwren_exmem=1. The regfile is write-first, so MEM/WB is not checked.
REQ-021 Data hazard when FWD_EN=1: memrden_idex=1, rdwren_idex=1, and a used ID source equals rd_idex.
REQ-022 The block SHALL resolve events in priority order: flush, then md stall, then data stall, then normal.
REQ-023 Flush response: clear_ifid=clear_idex=clear_exmem=1, pc_wren=1, wren_ifid=1, wren_idex=1.
REQ-024 md stall response: pc_wren=wren_ifid=wren_idex=0, clear_exmem=1, other clears 0.
REQ-025 Data stall response: pc_wren=wren_ifid=0, clear_idex=1, wren_idex=1, other clears 0.
REQ-026 Normal response: all wren=1, all clears=0.
REQ-027 md FSM states: IDLE and BUSY, with a down-counter md_cnt.
REQ-028 md_stall SHALL be (IDLE and md_start_idex) or (BUSY and md_cnt!=0).
REQ-029 Transition IDLE to BUSY when md_start_idex=1 and there is no flush; md_cnt loads MD_CYCLES-2.
REQ-030 In BUSY with md_cnt!=0, md_cnt SHALL decrement.
REQ-031 In BUSY with md_cnt=0: md_done=1, md_stall=0, next state IDLE.
REQ-032 Each multi-cycle op SHALL produce exactly MD_CYCLES-1 stall cycles.
REQ-033 A flush in any state SHALL force IDLE and md_cnt=0 next cycle, with md_done=0; the op is killed.
REQ-034 md_busy SHALL be 1 when the state is BUSY.
REQ-035 A data hazard coinciding with md_stall SHALL get the md stall response only, with no ID/EX bubble.
REQ-036 Forwarding when FWD_EN=1, fwd_a_sel from rs1_idex: 01 if rdwren_exmem and rd_exmem=rs1_idex!=0.
REQ-037 Otherwise fwd_a_sel SHALL be 10 if rdwren_memwb and rd_memwb=rs1_idex!=0, else 00. EX/MEM takes precedence.
REQ-038 fwd_b_sel SHALL follow the same rule from rs2_idex.
REQ-039 When FWD_EN=0, both fwd selects SHALL be constant 00.
REQ-040 stall_cnt SHALL increment on each cycle with pc_wren=0; flush_cnt SHALL increment on each flush cycle.
REQ-041 Both counters SHALL saturate at all-ones and SHALL not wrap.
REQ-042 cnt_clr=1 SHALL zero both counters next edge, taking precedence over increment.

Reset
REQ-043 While i_rst_n=0, the block SHALL immediately set: state IDLE, md_cnt=0, stall_cnt=flush_cnt=0.
REQ-044 While i_rst_n=0, outputs SHALL be forced: pc_wren=wren_ifid=wren_idex=0, all clears=1, fwd sels=00, md_busy=md_done=0.
REQ-045 Reset asserted mid-BUSY SHALL abandon the op.
REQ-046 After deassertion, the first edge SHALL evaluate from IDLE.

Verification
REQ-047 FWD_EN=0, rs1_ifid=5 used, rd_idex=5, rdwren_idex=1 -> pc_wren=0, wren_ifid=0, clear_idex=1; stall_cnt +1.
REQ-048 FWD_EN=1, same, memrden_idex=0, rd_exmem=5 on rs1_idex -> no stall; fwd_a_sel=01. With memrden_idex=1 -> load-use stall.
REQ-049 MD_CYCLES=4, md_start_idex held -> exactly 3 cycles wren_idex=0 and clear_exmem=1, md_done on 4th cycle, then IDLE.
REQ-050 Flush (pcsel_exmem=1, is_br_exmem=1) in 2nd BUSY cycle -> all clears=1 that cycle; next cycle md_busy=0, no md_done; flush_cnt=1.
REQ-051 rs2_ifid=0 with rd_idex=0 and rdwren_idex=1 -> no stall. Counter at all-ones plus stall -> holds all-ones; cnt_clr -> 0.
REQ-052 Assert i_rst_n=0 asynchronously while BUSY -> md_busy=0 and counters=0 without waiting for a clock edge.
